axil_reg_bridge: RTL
====================

# axil_reg_bridge

AXI4-Lite slave to simple register-bus initiator. Terminates AXI4-Lite transactions from the PCIe BAR interconnect and drives the single-cycle register bus (reg_wen / reg_addr / reg_wdata / reg_rdata) consumed by the design's register blocks. Serialises reads and writes, with one transaction outstanding at a time.

## Interface
- ADDR_LIMIT, 32'h0000_0014: first out-of-range byte address. Used only when the range check is compiled in.
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  reset, synchronous, active-low.
- s_axil_awaddr  in  32  write address.
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake.
- s_axil_araddr  in  32  read address.
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake.
- reg_wen  out  1  one-cycle write strobe.
- reg_addr  out  32  register address, word-aligned ({addr[31:2],2'b00}).
- reg_wdata  out  32  write data.
- reg_rdata  in  32  combinational read data for the current reg_addr.

## Operation
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_CAPT, RD_RESP.
- IDLE, write candidate: awvalid && wvalid are both high. A lone AW or a lone W is never accepted. Read candidate: arvalid.
- Only write candidate: grant write. Only read candidate: grant read. Both: grant the type not granted last (1-bit last_grant, reset = write, so the first tie goes to read).
- Write grant: awready = wready = 1 for that cycle. Capture the aligned address, data and wstrb, then go to WR_ISSUE.
- WR_ISSUE: reg_wen = 1 for exactly one cycle, only if wstrb == 4'hF. Go to WR_RESP.
- WR_RESP: bvalid = 1 and held until bready. bresp = OKAY (2'b00), or SLVERR (2'b10) if wstrb != 4'hF (write suppressed). Return to IDLE.
- Read grant: arready = 1. Capture the aligned address into reg_addr, then go to RD_CAPT.
- RD_CAPT: sample reg_rdata into the rdata holding register. Go to RD_RESP.
- RD_RESP: rvalid = 1 and held until rready. rresp = OKAY. rdata stays stable while rvalid is high. Return to IDLE.
- Readies are 0 in every state except IDLE. At most one of awready/arready is high in any cycle.
- reg_addr holds the last captured address between transactions. reg_wdata holds the last write data.

## Timing
- Reset values: all *ready = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, reg_wen = 0, reg_addr = 0, reg_wdata = 0, state = IDLE.
- Write, handshake at cycle T: reg_wen at T+1, bvalid from T+2. Minimum write-to-write spacing is 3 cycles with bready tied high.
- Read, handshake at cycle T: reg_addr valid from T+1, reg_rdata sampled at the end of T+1, rvalid from T+2.
- Next grant is possible in the cycle after the bvalid&&bready or rvalid&&rready cycle.
- Backpressure: bready/rready held low for N cycles keeps bvalid/rvalid and the data stable for N cycles. No new acceptance meanwhile.
- Reset mid-transaction: on the next edge, return to IDLE and drop all valids. The pending transaction is discarded. reg_wen is never asserted in the cycle after reset.

## Configuration
- AXIL_REG_BRIDGE_RANGE_CHK_EN defined: an aligned address >= ADDR_LIMIT is out of range.
  - Out-of-range write: no reg_wen pulse, bresp = SLVERR.
  - Out-of-range read: rdata = 0, rresp = SLVERR. reg_addr is still updated.
  - Timing is unchanged.
- AXIL_REG_BRIDGE_RANGE_CHK_EN undefined: every address is forwarded and responses are OKAY, except the partial-wstrb SLVERR. ADDR_LIMIT is ignored.

## Test plan
The bench register model has registers at 0x04, 0x08 and 0x0C with defaults 0x1111 / 0x2222 / 0x3333, and a read-only register at 0x10.
- After reset, read 0x08 -> rvalid 2 cycles after arready, rdata 0x00002222, rresp 00.
- Write 0xDEADBEEF to 0x06 with wstrb F -> one reg_wen pulse with reg_addr 0x04, bresp 00. A following read of 0x04 returns 0xDEADBEEF.
- Write with wstrb 4'h3 to 0x0C -> no reg_wen, bresp 10. A read of 0x0C still returns 0x3333.
- Assert AW+W and AR in the same cycle, repeatedly -> grants alternate read, write, read. Never are awready and arready high together.
- Hold rready low for 5 cycles during a read -> rvalid and rdata stay stable. A pending AW+W gets no awready until the R handshake.
- With AXIL_REG_BRIDGE_RANGE_CHK_EN, write/read 0x20 -> no reg_wen, SLVERR, rdata 0. Without the macro: reg_wen pulses, OKAY. Separately, aresetn low in WR_RESP -> bvalid 0 on the next edge and the bridge is idle.

Source files
------------

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite bus bundle shared by the register bridge and whatever drives it.
// The master modport is the initiator side (interconnect / bench); the slave
// modport is the side the bridge terminates.
interface axil_reg_bridge_if;
  // Write address channel
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  // Read address channel
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave that forwards each transaction, one at a
// time, onto a single-cycle register bus (reg_wen/reg_addr/reg_wdata/reg_rdata).
// A write needs AW and W together; ties between a write and a read alternate.
// Partial byte strobes suppress the register write and answer SLVERR.
//
// Optional build macro AXIL_REG_BRIDGE_RANGE_CHK_EN: word-aligned addresses at or
// above ADDR_LIMIT are rejected (no write pulse, read data forced to zero,
// SLVERR response). Without it ADDR_LIMIT has no effect.
module axil_reg_bridge #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0014
) (
  input  logic                aclk,
  input  logic                aresetn,
  axil_reg_bridge_if.slave    s_axil,
  output logic                reg_wen,
  output logic [31:0]         reg_addr,
  output logic [31:0]         reg_wdata,
  input  logic [31:0]         reg_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_CAPT  = 3'd3,
    RD_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic       GRANT_WR    = 1'b0;
  localparam logic       GRANT_RD    = 1'b1;

`ifdef AXIL_REG_BRIDGE_RANGE_CHK_EN
  localparam logic RANGE_CHK = 1'b1;
`else
  localparam logic RANGE_CHK = 1'b0;
`endif

  // Register bus is word addressed; the byte offset bits are dropped.
  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // True only when range checking is built in and the aligned address is past the map.
  function automatic logic addr_out_of_range(input logic [31:0] aligned);
    return RANGE_CHK && (aligned >= ADDR_LIMIT);
  endfunction

  // State and holding registers
  state_t      state_q,      state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] reg_addr_q,   reg_addr_d;
  logic [31:0] reg_wdata_q,  reg_wdata_d;
  logic        reg_wen_q,    reg_wen_d;
  logic        wr_err_q,     wr_err_d;
  logic        rd_err_q,     rd_err_d;
  logic        bvalid_q,     bvalid_d;
  logic [1:0]  bresp_q,      bresp_d;
  logic        rvalid_q,     rvalid_d;
  logic [1:0]  rresp_q,      rresp_d;
  logic [31:0] rdata_q,      rdata_d;

  // Combinational arbitration results
  logic        wr_cand_s;
  logic        rd_cand_s;
  logic        grant_wr_s;
  logic        grant_rd_s;
  logic [31:0] aw_aligned_s;
  logic [31:0] ar_aligned_s;
  logic        wr_reject_s;

  // Arbitrate between a complete write (AW+W) and a read while idle; ties alternate.
  always_comb begin
    wr_cand_s    = s_axil.awvalid & s_axil.wvalid;
    rd_cand_s    = s_axil.arvalid;
    grant_wr_s   = 1'b0;
    grant_rd_s   = 1'b0;
    aw_aligned_s = align_addr(s_axil.awaddr);
    ar_aligned_s = align_addr(s_axil.araddr);
    wr_reject_s  = (s_axil.wstrb != 4'hF) || addr_out_of_range(aw_aligned_s);
    if (state_q == IDLE) begin
      if (wr_cand_s && rd_cand_s) begin
        grant_wr_s = (last_grant_q == GRANT_RD);
        grant_rd_s = (last_grant_q == GRANT_WR);
      end else begin
        grant_wr_s = wr_cand_s;
        grant_rd_s = rd_cand_s;
      end
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  // Next-state and datapath updates for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wen_d    = 1'b0;
    wr_err_d     = wr_err_q;
    rd_err_d     = rd_err_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_wr_s) begin
          reg_addr_d   = aw_aligned_s;
          reg_wdata_d  = s_axil.wdata;
          wr_err_d     = wr_reject_s;
          reg_wen_d    = !wr_reject_s;
          last_grant_d = GRANT_WR;
          state_d      = WR_ISSUE;
        end else if (grant_rd_s) begin
          reg_addr_d   = ar_aligned_s;
          rd_err_d     = addr_out_of_range(ar_aligned_s);
          last_grant_d = GRANT_RD;
          state_d      = RD_CAPT;
        end else begin
          state_d      = IDLE;
        end
      end

      WR_ISSUE: begin
        // reg_wen_q is high during this state when the write was accepted.
        bvalid_d = 1'b1;
        bresp_d  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
        state_d  = WR_RESP;
      end

      WR_RESP: begin
        if (s_axil.bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = WR_RESP;
        end
      end

      RD_CAPT: begin
        rdata_d  = rd_err_q ? 32'h0000_0000 : reg_rdata;
        rresp_d  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
        rvalid_d = 1'b1;
        state_d  = RD_RESP;
      end

      RD_RESP: begin
        if (s_axil.rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = RD_RESP;
        end
      end

      default: begin
        bvalid_d = 1'b0;
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Register all state; synchronous active-low reset discards any pending transaction.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_WR;
      reg_addr_q   <= 32'h0000_0000;
      reg_wdata_q  <= 32'h0000_0000;
      reg_wen_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      rresp_q      <= 2'b00;
      rdata_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wen_q    <= reg_wen_d;
      wr_err_q     <= wr_err_d;
      rd_err_q     <= rd_err_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
    end
  end

  // Readies are the grant itself so a handshake lands in the same idle cycle.
  assign s_axil.awready = grant_wr_s;
  assign s_axil.wready  = grant_wr_s;
  assign s_axil.arready = grant_rd_s;

  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  assign reg_wen        = reg_wen_q;
  assign reg_addr       = reg_addr_q;
  assign reg_wdata      = reg_wdata_q;

endmodule
